// File: rtl/read_sched.sv
// Tag-search read scheduler: arbitrates requesters, reads a message's start/end
// location, then probes tags address by address. `READ_SCHED_RR_EN selects round-robin arbitration.
module read_sched #(
    parameter int TAG_WIDTH   = 32,
    parameter int NUM_MESSAGE = 10,
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int MSG_ID_W    = (NUM_MESSAGE > 1) ? $clog2(NUM_MESSAGE) : 1,
    parameter int REQ_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*MSG_ID_W-1:0]   req_msg_id_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          loc_rd_o,
    output logic [MSG_ID_W-1:0]           loc_rd_id_o,
    input  logic [ADDR_WIDTH-1:0]         loc_start_addr_i,
    input  logic [ADDR_WIDTH-1:0]         loc_end_addr_i,
    output logic                          search_tag_o,
    output logic [ADDR_WIDTH-1:0]         search_addr_o,
    output logic [TAG_WIDTH-1:0]          search_tag_val_o,
    input  logic                          tag_match_i,
    output logic                          rsp_valid_o,
    output logic                          rsp_found_o,
    output logic                          rsp_err_o,
    output logic [ADDR_WIDTH-1:0]         rsp_addr_o,
    output logic [REQ_ID_W-1:0]           rsp_id_o,
    output logic                          busy_o,
    output logic [2:0]                    dbg_state_o
);

    // Handshake: req_i is a level held by the requester until its gnt_o pulse;
    // rsp_valid_o is a single-cycle pulse with no back-pressure.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOC_RD  = 3'd1,
        LOC_CAP = 3'd2,
        SEARCH  = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state;
    logic [MSG_ID_W-1:0]   lat_id_q;
    logic [TAG_WIDTH-1:0]  lat_tag_q;
    logic [REQ_ID_W-1:0]   lat_req_q;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] end_q;

    logic                  win_vld;
    logic [REQ_ID_W-1:0]   win_idx;
    logic [MSG_ID_W-1:0]   win_id;
    logic [TAG_WIDTH-1:0]  win_tag;
    logic                  win_id_bad;
    logic                  lat_id_bad;
    int                    cand;

`ifdef READ_SCHED_RR_EN
    logic [REQ_ID_W-1:0]   rr_ptr_q;
`endif

    assign dbg_state_o = state;
    assign lat_id_bad  = (32'(lat_id_q) >= 32'(NUM_MESSAGE));

    // Scan starts just after the last winner in round-robin mode, at index 0 otherwise.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef READ_SCHED_RR_EN
            cand = (int'(rr_ptr_q) + 1 + i) % NUM_REQ;
`else
            cand = i;
`endif
            if (!win_vld && req_i[REQ_ID_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = REQ_ID_W'(cand);
            end
        end
    end

    always_comb begin
        win_id     = req_msg_id_i[int'(win_idx)*MSG_ID_W +: MSG_ID_W];
        win_tag    = req_tag_i[int'(win_idx)*TAG_WIDTH +: TAG_WIDTH];
        win_id_bad = (32'(win_id) >= 32'(NUM_MESSAGE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lat_id_q         <= '0;
            lat_tag_q        <= '0;
            lat_req_q        <= '0;
            cur_q            <= '0;
            end_q            <= '0;
            gnt_o            <= '0;
            loc_rd_o         <= 1'b0;
            loc_rd_id_o      <= '0;
            search_tag_o     <= 1'b0;
            search_addr_o    <= '0;
            search_tag_val_o <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_found_o      <= 1'b0;
            rsp_err_o        <= 1'b0;
            rsp_addr_o       <= '0;
            rsp_id_o         <= '0;
            busy_o           <= 1'b0;
`ifdef READ_SCHED_RR_EN
            rr_ptr_q         <= REQ_ID_W'(NUM_REQ - 1);
`endif
        end else begin
            // Strobes and response fields are pulses; each state re-asserts what it needs.
            gnt_o            <= '0;
            loc_rd_o         <= 1'b0;
            loc_rd_id_o      <= '0;
            search_tag_o     <= 1'b0;
            search_addr_o    <= '0;
            search_tag_val_o <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_found_o      <= 1'b0;
            rsp_err_o        <= 1'b0;
            rsp_addr_o       <= '0;
            rsp_id_o         <= '0;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        lat_id_q  <= win_id;
                        lat_tag_q <= win_tag;
                        lat_req_q <= win_idx;
                        gnt_o     <= NUM_REQ'(1) << win_idx;
                        loc_rd_o  <= !win_id_bad;
                        if (!win_id_bad) loc_rd_id_o <= win_id;
                        busy_o    <= 1'b1;
                        state     <= LOC_RD;
`ifdef READ_SCHED_RR_EN
                        rr_ptr_q  <= win_idx;
`endif
                    end
                end
                LOC_RD: begin
                    if (lat_id_bad) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_id_o    <= lat_req_q;
                        state       <= DONE;
                    end else begin
                        state <= LOC_CAP;
                    end
                end
                LOC_CAP: begin
                    cur_q <= loc_start_addr_i;
                    end_q <= loc_end_addr_i;
                    if (loc_start_addr_i > loc_end_addr_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= lat_req_q;
                        state       <= DONE;
                    end else begin
                        search_tag_o     <= 1'b1;
                        search_addr_o    <= loc_start_addr_i;
                        search_tag_val_o <= lat_tag_q;
                        state            <= SEARCH;
                    end
                end
                SEARCH: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (tag_match_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_found_o <= 1'b1;
                        rsp_addr_o  <= cur_q;
                        rsp_id_o    <= lat_req_q;
                        state       <= DONE;
                    end else if (cur_q == end_q) begin
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= lat_req_q;
                        state       <= DONE;
                    end else begin
                        cur_q            <= cur_q + ADDR_WIDTH'(1);
                        search_tag_o     <= 1'b1;
                        search_addr_o    <= cur_q + ADDR_WIDTH'(1);
                        search_tag_val_o <= lat_tag_q;
                        state            <= SEARCH;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_sched.sv
// Directed bench for read_sched with location/tag memory responders and a response scoreboard.
module tb_read_sched;

    localparam int TW = 32;
    localparam int MW = 4;
    localparam int AW = 8;
    localparam int NR = 2;
    localparam int EW = 1 + 1 + AW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_i = '0;
    logic [NR*MW-1:0]  req_msg_id_i = '0;
    logic [NR*TW-1:0]  req_tag_i = '0;
    logic [NR-1:0]     gnt_o;
    logic              loc_rd_o;
    logic [MW-1:0]     loc_rd_id_o;
    logic [AW-1:0]     loc_start_addr_i = '0;
    logic [AW-1:0]     loc_end_addr_i = '0;
    logic              search_tag_o;
    logic [AW-1:0]     search_addr_o;
    logic [TW-1:0]     search_tag_val_o;
    logic              tag_match_i = 1'b0;
    logic              rsp_valid_o;
    logic              rsp_found_o;
    logic              rsp_err_o;
    logic [AW-1:0]     rsp_addr_o;
    logic              rsp_id_o;
    logic              busy_o;
    logic [2:0]        dbg_state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int loc_rd_n = 0;
    logic pend = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            cyc_q[$];
    logic [AW-1:0] srch_q[$];

    logic [AW-1:0] start_mem [16];
    logic [AW-1:0] end_mem   [16];
    logic [TW-1:0] tag_mem   [256];

    wire [60:0] all_outs = {gnt_o, loc_rd_o, loc_rd_id_o, search_tag_o, search_addr_o,
                            search_tag_val_o, rsp_valid_o, rsp_found_o, rsp_err_o,
                            rsp_addr_o, rsp_id_o, busy_o};

    read_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req_i),
        .req_msg_id_i     (req_msg_id_i),
        .req_tag_i        (req_tag_i),
        .gnt_o            (gnt_o),
        .loc_rd_o         (loc_rd_o),
        .loc_rd_id_o      (loc_rd_id_o),
        .loc_start_addr_i (loc_start_addr_i),
        .loc_end_addr_i   (loc_end_addr_i),
        .search_tag_o     (search_tag_o),
        .search_addr_o    (search_addr_o),
        .search_tag_val_o (search_tag_val_o),
        .tag_match_i      (tag_match_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_found_o      (rsp_found_o),
        .rsp_err_o        (rsp_err_o),
        .rsp_addr_o       (rsp_addr_o),
        .rsp_id_o         (rsp_id_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Location table answers the cycle after loc_rd_o; tag compare answers the cycle after search_tag_o
    always @(negedge clk) begin
        if (!rst_n) begin
            tag_match_i = 1'b0;
            pend        = 1'b0;
        end else begin
            tag_match_i = pend;
            pend = search_tag_o && (tag_mem[search_addr_o] == search_tag_val_o);
            if (search_tag_o) srch_q.push_back(search_addr_o);
            if (loc_rd_o) begin
                loc_start_addr_i = start_mem[loc_rd_id_o];
                loc_end_addr_i   = end_mem[loc_rd_id_o];
                loc_rd_n++;
            end
        end
    end

    // Scoreboard: fields {found, err, addr, id} and the cycle rsp_valid_o is due (-1 = any)
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            c;
        if (rst_n && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("rsp_fields", {rsp_found_o, rsp_err_o, rsp_addr_o, rsp_id_o}, e);
                if (c >= 0) check("rsp_cycle", cyc, c);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_req", busy_o, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rsp_drain", exp_q.size(), 0);
    endtask

    task automatic do_req(input int r, input logic [MW-1:0] id, input logic [TW-1:0] tag,
                          input int lat, input logic found, input logic err,
                          input logic [AW-1:0] addr);
        wait_idle();
        srch_q.delete();
        loc_rd_n = 0;
        req_msg_id_i[r*MW +: MW] = id;
        req_tag_i[r*TW +: TW]    = tag;
        req_i[r]                 = 1'b1;
        exp_q.push_back({found, err, addr, 1'(r)});
        cyc_q.push_back(cyc + lat);
        @(negedge clk);
        check("gnt", gnt_o, NR'(1) << r);
        check("busy_in_flight", busy_o, 1);
        req_i[r] = 1'b0;
        wait_drain();
    endtask

    initial begin
        int n;
        int n_g;
        for (int i = 0; i < 256; i++) tag_mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            start_mem[i] = '0;
            end_mem[i]   = '0;
        end
        start_mem[3] = 8'h10; end_mem[3] = 8'h14;
        start_mem[4] = 8'h20; end_mem[4] = 8'h22;
        start_mem[5] = 8'h30; end_mem[5] = 8'h2F;
        start_mem[6] = 8'hFF; end_mem[6] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs, 0);
        check("reset_state", dbg_state_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Match at the first address
        tag_mem[8'h10] = 32'h0000_0023;
        do_req(0, 4'd3, 32'h0000_0023, 5, 1'b1, 1'b0, 8'h10);
        check("first_match_loc_rd", loc_rd_n, 1);
        check("first_match_searches", srch_q.size(), 1);

        // Match only at the last address: five probes 0x10..0x14
        tag_mem[8'h10] = '0;
        tag_mem[8'h14] = 32'h0000_0023;
        do_req(0, 4'd3, 32'h0000_0023, 13, 1'b1, 1'b0, 8'h14);
        check("last_match_searches", srch_q.size(), 5);
        for (int i = 0; i < 5 && srch_q.size() != 0; i++)
            check("last_match_addr", srch_q.pop_front(), 8'h10 + i);

        // No match over three addresses
        do_req(0, 4'd4, 32'h0000_0055, 9, 1'b0, 1'b0, 8'h00);
        check("no_match_searches", srch_q.size(), 3);

        // Empty range: start > end
        do_req(0, 4'd5, 32'h0000_0055, 3, 1'b0, 1'b0, 8'h00);
        check("empty_range_searches", srch_q.size(), 0);

        // Out-of-range message index
        do_req(0, 4'd12, 32'h0000_0023, 2, 1'b0, 1'b1, 8'h00);
        check("bad_id_loc_rd", loc_rd_n, 0);
        check("bad_id_searches", srch_q.size(), 0);

        // Requester 1, match at the top address
        tag_mem[8'hFF] = 32'h0000_0077;
        do_req(1, 4'd6, 32'h0000_0077, 5, 1'b1, 1'b0, 8'hFF);

        // Both requesters held for four grants
        wait_idle();
        req_msg_id_i = {4'd5, 4'd3};
        req_tag_i    = {32'h0000_0099, 32'h0000_0023};
        for (int t = 0; t < 4; t++) begin
`ifdef READ_SCHED_RR_EN
            if (t % 2 == 0) exp_q.push_back({1'b1, 1'b0, 8'h14, 1'b0});
            else            exp_q.push_back({1'b0, 1'b0, 8'h00, 1'b1});
`else
            exp_q.push_back({1'b1, 1'b0, 8'h14, 1'b0});
`endif
            cyc_q.push_back(-1);
        end
        req_i = 2'b11;
        n = 0;
        n_g = 0;
        while (n_g < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (gnt_o != '0) n_g++;
        end
        req_i = 2'b00;
        check("arb_grant_count", n_g, 4);
        wait_drain();

        // Reset during SEARCH aborts silently
        wait_idle();
        req_msg_id_i[0 +: MW] = 4'd3;
        req_tag_i[0 +: TW]    = 32'h0000_0023;
        req_i[0]              = 1'b1;
        @(negedge clk);
        req_i[0] = 1'b0;
        n = 0;
        while (search_tag_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_search_seen", search_tag_o, 1);
        rst_n = 1'b0;
        #1;
        check("abort_outs", all_outs, 0);
        check("abort_state", dbg_state_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", busy_o, 0);

        // First request after reset completes normally
        tag_mem[8'h14] = '0;
        tag_mem[8'h10] = 32'h0000_0023;
        do_req(0, 4'd3, 32'h0000_0023, 5, 1'b1, 1'b0, 8'h10);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
